// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, error codes
// and the instruction word field split used by both loader and fetch path.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    PAYLOAD,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CHK     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  function automatic logic [15:0] opcode_of(input logic [31:0] w);
    return w[31:16];
  endfunction

  function automatic logic [15:0] operand_of(input logic [31:0] w);
    return w[15:0];
  endfunction

endpackage

// File: rtl/prog_loader_asm.sv
// Payload byte assembler: 24-bit shifter plus incoming byte forms the word,
// 2-bit byte index marks the 4th byte, running XOR covers payload bytes only.
module prog_loader_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_ready,
  output logic [31:0] word,
  output logic [7:0]  acc
);

  logic [23:0] shreg;
  logic [1:0]  idx;

  // The 4th byte is taken straight from the input so the word is complete on its sampling edge.
  assign word_ready = byte_valid && (idx == 2'd3);
  assign word       = {shreg, byte_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      idx   <= '0;
      acc   <= '0;
    end else if (clear) begin
      shreg <= '0;
      idx   <= '0;
      acc   <= '0;
    end else if (byte_valid) begin
      shreg <= {shreg[15:0], byte_data};
      idx   <= idx + 2'd1;
      acc   <= acc ^ byte_data;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program memory writer: parses LEN_HI, LEN_LO, N*4 payload bytes, CHK and writes words.
// Optional idle timeout is built when PROG_LOADER_TIMEOUT_EN is defined.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [15:0]           word_count,
  output state_t                fsm_state
);

  localparam logic [15:0] DEPTH_N = 16'(DEPTH);

  // Handshake: rx_valid is a one-cycle strobe with no backpressure; a byte is
  // consumed on the edge where it is high, unless load_start is high in that cycle.
  state_t      state, state_next;
  logic [1:0]  err_next;
  logic [15:0] len_q;
  logic [15:0] len_in;
  logic        pay_valid;
  logic        word_ready;
  logic [31:0] word;
  logic [7:0]  acc;
  logic        timeout_hit;

  assign len_in    = {len_q[15:8], rx_data};
  assign pay_valid = (state == PAYLOAD) && rx_valid && !load_start;
  assign busy      = (state == LEN_HI) || (state == LEN_LO) ||
                     (state == PAYLOAD) || (state == CHECK);
  assign done      = (state == DONE);
  assign error     = (state == ERROR);
  assign fsm_state = state;

  prog_loader_asm u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (load_start),
    .byte_valid (pay_valid),
    .byte_data  (rx_data),
    .word_ready (word_ready),
    .word       (word),
    .acc        (acc)
  );

`ifdef PROG_LOADER_TIMEOUT_EN
  logic [31:0] idle_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (load_start || (busy && rx_valid) || !busy) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end

  // Fires on the edge where the idle count would reach TIMEOUT_CYCLES.
  assign timeout_hit = busy && !rx_valid && (idle_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_next = state;
    err_next   = err_code;
    if (load_start) begin
      state_next = LEN_HI;
      err_next   = ERR_NONE;
    end else if (timeout_hit) begin
      state_next = ERROR;
      err_next   = ERR_TIMEOUT;
    end else begin
      case (state)
        LEN_HI:  if (rx_valid) state_next = LEN_LO;
        LEN_LO: begin
          if (rx_valid) begin
            if (len_in == 16'd0) begin
              state_next = CHECK;
            end else if (len_in > DEPTH_N) begin
              state_next = ERROR;
              err_next   = ERR_LEN;
            end else begin
              state_next = PAYLOAD;
            end
          end
        end
        PAYLOAD: if (word_ready && (word_count == len_q - 16'd1)) state_next = CHECK;
        CHECK: begin
          if (rx_valid) begin
            if (rx_data == acc) begin
              state_next = DONE;
            end else begin
              state_next = ERROR;
              err_next   = ERR_CHK;
            end
          end
        end
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      err_code <= ERR_NONE;
    end else begin
      state    <= state_next;
      err_code <= err_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q      <= '0;
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
    end else begin
      if (!load_start && rx_valid && (state == LEN_HI)) len_q[15:8] <= rx_data;
      if (!load_start && rx_valid && (state == LEN_LO)) len_q[7:0]  <= rx_data;
      mem_we <= word_ready;
      if (load_start) begin
        word_count <= '0;
      end else if (word_ready) begin
        // word_count doubles as the write index; N <= DEPTH keeps it in range.
        mem_waddr  <= word_count[ADDR_WIDTH-1:0];
        mem_wdata  <= {opcode_of(word), operand_of(word)};
        word_count <= word_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: framed byte stimulus, write scoreboard,
// done/error/err_code status checks and reset behaviour.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    err_code;
  logic [15:0]   word_count;
  state_t        fsm_state;

  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] mon_exp;
  logic [31:0]    frame_words[$];
  int check_cnt = 0;
  int pass_cnt  = 0;

  prog_loader #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(50)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code),
    .word_count (word_count),
    .fsm_state  (fsm_state)
  );

  always #5 clk = ~clk;

  // Write monitor: every mem_we pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (rst === 1'b0 && mem_we === 1'b1) begin
      check_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write got addr=%0h data=%08h exp none", mem_waddr, mem_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({mem_waddr, mem_wdata} !== mon_exp)
          $display("FAIL write got addr=%0h data=%08h exp addr=%0h data=%08h",
                   mem_waddr, mem_wdata, mon_exp[AW+31:32], mon_exp[31:0]);
        else pass_cnt++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int idx);
    logic [AW-1:0] a;
    a = AW'(idx);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    exp_q.push_back({a, w});
    @(negedge clk);
    check_cnt++;
    if (mem_we !== 1'b1) $display("FAIL write_timing word=%0d got mem_we=%0b exp 1", idx, mem_we);
    else pass_cnt++;
  endtask

  // Sends a whole frame built from frame_words; checksum from the model unless overridden.
  task automatic run_frame(input logic use_ovr, input logic [7:0] ovr);
    logic [15:0] n;
    logic [7:0]  chk;
    n   = 16'(frame_words.size());
    chk = 8'h00;
    pulse_start();
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    for (int i = 0; i < frame_words.size(); i++) begin
      send_word(frame_words[i], i);
      chk = chk ^ frame_words[i][31:24] ^ frame_words[i][23:16]
                ^ frame_words[i][15:8] ^ frame_words[i][7:0];
    end
    send_byte(use_ovr ? ovr : chk);
    @(negedge clk);
  endtask

  task automatic check_status(input string name, input logic exp_done, input logic exp_err,
                              input logic [1:0] exp_code, input logic [15:0] exp_wc);
    check_cnt++;
    if (done !== exp_done) $display("FAIL %s_done got %0b exp %0b", name, done, exp_done);
    else pass_cnt++;
    check_cnt++;
    if (error !== exp_err) $display("FAIL %s_error got %0b exp %0b", name, error, exp_err);
    else pass_cnt++;
    check_cnt++;
    if (err_code !== exp_code) $display("FAIL %s_err_code got %0b exp %0b", name, err_code, exp_code);
    else pass_cnt++;
    check_cnt++;
    if (word_count !== exp_wc) $display("FAIL %s_word_count got %0d exp %0d", name, word_count, exp_wc);
    else pass_cnt++;
    check_cnt++;
    if (busy !== 1'b0) $display("FAIL %s_busy got %0b exp 0", name, busy);
    else pass_cnt++;
    check_cnt++;
    if (exp_q.size() != 0) $display("FAIL %s_writes_missing got %0d pending exp 0", name, exp_q.size());
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    check_cnt++;
    if ({mem_we, mem_waddr, mem_wdata, busy, done, error, err_code, word_count} !== '0)
      $display("FAIL %s_outputs got we=%0b addr=%0h data=%08h busy=%0b done=%0b err=%0b code=%0b wc=%0d exp all 0",
               name, mem_we, mem_waddr, mem_wdata, busy, done, error, err_code, word_count);
    else pass_cnt++;
    check_cnt++;
    if (fsm_state !== IDLE) $display("FAIL %s_state got %0d exp %0d", name, fsm_state, IDLE);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; load_start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_good_frame();
    frame_words = '{32'h30100005, 32'h1234ABCD};
    run_frame(1'b0, 8'h00);
    check_status("good", 1'b1, 1'b0, ERR_NONE, 16'd2);
  endtask

  task automatic test_bad_checksum();
    frame_words = '{32'h30100005, 32'h1234ABCD};
    run_frame(1'b1, 8'h00);
    check_status("badchk", 1'b0, 1'b1, ERR_CHK, 16'd2);
  endtask

  task automatic test_len_overflow();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h11);
    @(negedge clk);
    check_status("lenovf", 1'b0, 1'b1, ERR_LEN, 16'd0);
    for (int i = 0; i < 6; i++) send_byte(8'(i));
  endtask

  task automatic test_zero_len();
    frame_words.delete();
    run_frame(1'b0, 8'h00);
    check_status("zerolen", 1'b1, 1'b0, ERR_NONE, 16'd0);
  endtask

  task automatic test_restart();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    frame_words = '{32'h00000007};
    run_frame(1'b0, 8'h00);
    check_status("restart", 1'b1, 1'b0, ERR_NONE, 16'd1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 3; t++) begin
      int n;
      n = $urandom_range(1, DEPTH);
      frame_words.delete();
      for (int i = 0; i < n; i++) frame_words.push_back($urandom);
      run_frame(1'b0, 8'h00);
      check_status("random", 1'b1, 1'b0, ERR_NONE, 16'(n));
    end
  endtask

  task automatic test_stall();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
`ifdef PROG_LOADER_TIMEOUT_EN
    repeat (49) @(posedge clk);
    @(negedge clk);
    check_cnt++;
    if (busy !== 1'b1 || error !== 1'b0) $display("FAIL timeout_early got busy=%0b error=%0b exp 1/0", busy, error);
    else pass_cnt++;
    @(negedge clk);
    check_status("timeout", 1'b0, 1'b1, ERR_TIMEOUT, 16'd0);
`else
    repeat (60) @(posedge clk);
    @(negedge clk);
    check_cnt++;
    if (busy !== 1'b1 || error !== 1'b0 || err_code !== ERR_NONE)
      $display("FAIL stall_wait got busy=%0b error=%0b code=%0b exp 1/0/0", busy, error, err_code);
    else pass_cnt++;
    send_word(32'hDEAD0001, 0);
    send_word(32'h0002BEEF, 1);
    send_byte(8'hDE ^ 8'hAD ^ 8'h00 ^ 8'h01 ^ 8'h00 ^ 8'h02 ^ 8'hBE ^ 8'hEF);
    @(negedge clk);
    check_status("stall", 1'b1, 1'b0, ERR_NONE, 16'd2);
`endif
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(32'hCAFE1234, 0);
    send_byte(8'h55);
    send_byte(8'h66);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rstmid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_byte(8'h77);
    send_byte(8'h88);
    @(negedge clk);
    check_status("rstmid_after", 1'b0, 1'b0, ERR_NONE, 16'd0);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_len_overflow();
    test_zero_len();
    test_restart();
    test_random();
    test_stall();
    test_reset_mid();
    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
